rmio_seq: RTL and testbench
===========================

# rmio_seq

RF-side operand sequencer driving the `rf` modport of `rmio_intf`. It accepts one command: up to INPUT_NUM source and OUTPUT_NUM destination register-file addresses. It then reads each source word from the RF RAM into the EU input slots. After the EU latency it pulls each EU output and writes it back to the RF RAM, then signals done. It sits between the register-file RAM and `rmio_intf`, directly upstream/downstream of the executing unit.

## Interface
- INPUT_NUM, 4, EU input slots; matches `rmio_intf` INPUT_NUM
- OUTPUT_NUM, 2, EU output slots; matches `rmio_intf` OUTPUT_NUM
- DATA_W, 1408, RF word / slot width
- ADDR_W, 8, RF RAM address width
- EU_LAT, 4, cycles from last input_we to first output_re; must be ≥1
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE and not in reset
- cmd_src  in  INPUT_NUM*ADDR_W  source address of slot i at [i*ADDR_W +: ADDR_W]
- cmd_dst  in  OUTPUT_NUM*ADDR_W  destination address of output j, same packing
- cmd_in_cnt  in  $clog2(INPUT_NUM+1)  slots to load (0..INPUT_NUM)
- cmd_out_cnt  in  $clog2(OUTPUT_NUM+1)  outputs to store
- done  out  1  one-cycle pulse at command completion
- ram_re  out  1  RF read enable; ram_rdata valid exactly 1 cycle later
- ram_raddr  out  ADDR_W  read address
- ram_rdata  in  DATA_W  read data
- ram_we  out  1  RF write enable
- ram_waddr  out  ADDR_W  write address
- ram_wdata  out  DATA_W  write data
- rmio  modport  rmio_intf.rf  drives input_data, input_we, output_re; samples output_data
- eu_done  in  1  present only with RMIO_SEQ_EU_DONE_EN

## Operation
- FSM states: IDLE, READ, WAIT, WRITE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch src/dst/counts. Counts above the maximum clamp to INPUT_NUM/OUTPUT_NUM. Next state is READ if in_cnt>0, else WAIT.
- READ: one cycle per slot k=0..n-1: ram_re=1, ram_raddr=src[k]. A registered one-hot slot index follows ram_re by one cycle. After slot n-1, go to WAIT.
- Load path: input_we = registered one-hot (bit k). input_data = ram_rdata while input_we≠0, else 0. The final input_we fires in the first WAIT cycle.
- WAIT: a down-counter loaded with EU_LAT runs EU_LAT cycles. Then go to WRITE, or to IDLE if out_cnt=0.
- WRITE: one cycle per output j=0..m-1: output_re=one-hot bit j, ram_we=1, ram_waddr=dst[j], ram_wdata=output_data (combinational pass-through). After output m-1, go to IDLE.
- done pulses in the first IDLE cycle after WAIT/WRITE. A new command may be accepted in that same cycle.
- cmd_valid is ignored while not IDLE. The latched command is immune to input changes.

## Timing
- Handshake in cycle 0, n=in_cnt, m=out_cnt:
  - ram_re in cycles 1..n
  - input_we in cycles 2..n+1
  - output_re/ram_we in cycles n+EU_LAT+1..n+EU_LAT+m
  - done at n+EU_LAT+m+1
- Reset values: ram_re, ram_we, input_we, output_re, done = 0; input_data, addresses, ram_wdata = 0; state IDLE; cmd_ready=0 while rst=1.
- Reset mid-command: the next cycle has all outputs at reset values. In-flight input_we is flushed, no further RAM write occurs, and done is not pulsed.

## Configuration
- RMIO_SEQ_EU_DONE_EN defined: port eu_done exists and the WAIT counter is removed.
  - WAIT lasts until eu_done=1 is sampled in WAIT.
  - WRITE starts the next cycle.
  - eu_done outside WAIT is ignored.
  - EU_LAT is unused.
- Not defined: fixed EU_LAT wait, no eu_done port.

## Structure
- Shared package rmio_pkg: the state enum (IDLE/READ/WAIT/WRITE) and a count-width localparam function used by both rmio_seq and its bench.
- Single module. No sub-module; the RF RAM is external.

## Test plan
- Params 4/2/EU_LAT=4; src={3,7,1,0x20}, dst={0x40,0x41}, counts 4/2, accepted at cycle 0 -> ram_raddr 3,7,1,0x20 in cycles 1-4; input_we 0001,0010,0100,1000 in cycles 2-5 with input_data equal to the RAM words; output_re 01@9, 10@10; ram_waddr 0x40,0x41 with wdata=output_data; done@11.
- in_cnt=0, out_cnt=1, dst={0x05} -> no ram_re/input_we; output_re=01 and ram_waddr=0x05 at cycle 5; done@6.
- in_cnt=7, out_cnt=3 -> clamped to 4/2, identical timing to scenario 1.
- Second command held on cmd_valid during the first -> cmd_ready=0 cycles 1-10; accepted at cycle 11 (with done); its first ram_re@12.
- rst asserted at cycle 3 of scenario 1 -> cycle 4 all outputs 0, no input_we, no ram_we, no done; cmd_ready=1 the first cycle after rst deasserts.
- With RMIO_SEQ_EU_DONE_EN: eu_done pulse in IDLE ignored; eu_done@20 during WAIT -> output_re=01@21, done@23.

Source files
------------

// File: rtl/rmio_pkg.sv
// rmio_pkg - definitions shared by the RF-side operand sequencer and its bench.
//   rmio_state_e : sequencer FSM state encoding (IDLE/READ/WAIT/WRITE)
//   cnt_w()      : width of a counter that must hold 0..max_val inclusive
package rmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } rmio_state_e;

  // Never returns 0 so that a count port always has at least one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rmio_intf.sv
// rmio_intf - link between the RF-side sequencer and the executing unit (EU).
//   input_data  : one RF word, written into the EU input slot(s) flagged by input_we
//   input_we    : one-hot EU input slot write enable
//   output_re   : one-hot EU output slot read enable
//   output_data : word of the EU output slot selected by output_re (EU-driven)
// Modports: rf (sequencer side), eu (executing-unit side).
interface rmio_intf #(
  parameter int INPUT_NUM  = 4,
  parameter int OUTPUT_NUM = 2,
  parameter int DATA_W     = 1408
);
  logic [DATA_W-1:0]     input_data;
  logic [INPUT_NUM-1:0]  input_we;
  logic [OUTPUT_NUM-1:0] output_re;
  logic [DATA_W-1:0]     output_data;

  modport rf (output input_data, output input_we, output output_re, input output_data);
  modport eu (input input_data, input input_we, input output_re, output output_data);
endinterface

// File: rtl/rmio_seq.sv
// rmio_seq - RF-side operand sequencer.
// Accepts one command (up to INPUT_NUM source and OUTPUT_NUM destination RF
// addresses), reads each source word from the RF RAM into the EU input slots,
// waits for the EU, then pulls each EU output and writes it back to the RF RAM,
// and finally pulses done.
//
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   cmd_valid/ready   : command handshake (ready only in IDLE and not in reset)
//   cmd_src, cmd_dst  : packed addresses, slot i at [i*ADDR_W +: ADDR_W]
//   cmd_in_cnt/out_cnt: slots to load / outputs to store (clamped to max)
//   done              : one-cycle pulse on command completion
//   ram_re/raddr/rdata: RF read port, rdata valid one cycle after ram_re
//   ram_we/waddr/wdata: RF write port
//   rmio              : rmio_intf.rf modport towards the EU
//   eu_done           : EU completion strobe (only with RMIO_SEQ_EU_DONE_EN)
//   dbg_state         : current FSM state, for observation
//
// Configuration macro RMIO_SEQ_EU_DONE_EN: when defined, WAIT lasts until
// eu_done is sampled high in WAIT instead of a fixed EU_LAT cycles.
//
// Handshake semantics: a command transfers on a rising edge where
// cmd_valid && cmd_ready; the command fields are captured on that edge and
// later changes on the inputs have no effect until the next transfer.
module rmio_seq
  import rmio_pkg::*;
#(
  parameter int INPUT_NUM  = 4,
  parameter int OUTPUT_NUM = 2,
  parameter int DATA_W     = 1408,
  parameter int ADDR_W     = 8,
  parameter int EU_LAT     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [INPUT_NUM*ADDR_W-1:0]      cmd_src,
  input  logic [OUTPUT_NUM*ADDR_W-1:0]     cmd_dst,
  input  logic [cnt_w(INPUT_NUM)-1:0]      cmd_in_cnt,
  input  logic [cnt_w(OUTPUT_NUM)-1:0]     cmd_out_cnt,
  output logic                             done,
  output logic                             ram_re,
  output logic [ADDR_W-1:0]                ram_raddr,
  input  logic [DATA_W-1:0]                ram_rdata,
  output logic                             ram_we,
  output logic [ADDR_W-1:0]                ram_waddr,
  output logic [DATA_W-1:0]                ram_wdata,
  rmio_intf.rf                             rmio,
`ifdef RMIO_SEQ_EU_DONE_EN
  input  logic                             eu_done,
`endif
  output logic [1:0]                       dbg_state
);

  localparam int IN_CW  = cnt_w(INPUT_NUM);
  localparam int OUT_CW = cnt_w(OUTPUT_NUM);
`ifndef RMIO_SEQ_EU_DONE_EN
  localparam int WAIT_W = cnt_w(EU_LAT);
`endif

  rmio_state_e                 state_q, state_d;
  logic [INPUT_NUM*ADDR_W-1:0]  src_q, src_d;
  logic [OUTPUT_NUM*ADDR_W-1:0] dst_q, dst_d;
  logic [IN_CW-1:0]             in_cnt_q, in_cnt_d;
  logic [OUT_CW-1:0]            out_cnt_q, out_cnt_d;
  logic [IN_CW-1:0]             rd_idx_q, rd_idx_d;
  logic [OUT_CW-1:0]            wr_idx_q, wr_idx_d;
  logic [INPUT_NUM-1:0]         ld_oh_q, ld_oh_d;   // slot being loaded, one cycle behind ram_re
  logic                         done_q, done_d;
`ifndef RMIO_SEQ_EU_DONE_EN
  logic [WAIT_W-1:0]            wait_cnt_q, wait_cnt_d;
`endif

  logic [IN_CW-1:0]             in_clamp;
  logic [OUT_CW-1:0]            out_clamp;
  logic [OUTPUT_NUM-1:0]        out_re;
  logic                         wait_over;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    rd_idx_d  = rd_idx_q;
    wr_idx_d  = wr_idx_q;
    ld_oh_d   = '0;
    done_d    = 1'b0;
`ifndef RMIO_SEQ_EU_DONE_EN
    wait_cnt_d = wait_cnt_q;
`endif
    cmd_ready = (state_q == ST_IDLE) && !rst;
    ram_re    = 1'b0;
    ram_raddr = '0;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    out_re    = '0;
    wait_over = 1'b0;

    in_clamp  = (int'(cmd_in_cnt) > INPUT_NUM) ? IN_CW'(INPUT_NUM) : cmd_in_cnt;
    out_clamp = (int'(cmd_out_cnt) > OUTPUT_NUM) ? OUT_CW'(OUTPUT_NUM) : cmd_out_cnt;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          src_d     = cmd_src;
          dst_d     = cmd_dst;
          in_cnt_d  = in_clamp;
          out_cnt_d = out_clamp;
          rd_idx_d  = '0;
          wr_idx_d  = '0;
          if (in_clamp != '0) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_WAIT;
`ifndef RMIO_SEQ_EU_DONE_EN
            wait_cnt_d = WAIT_W'(EU_LAT - 1);
`endif
          end
        end
      end

      ST_READ: begin
        ram_re    = 1'b1;
        ram_raddr = src_q[int'(rd_idx_q)*ADDR_W +: ADDR_W];
        ld_oh_d   = INPUT_NUM'(1) << rd_idx_q;
        if (rd_idx_q + IN_CW'(1) == in_cnt_q) begin
          // The last slot's input_we lands in the first WAIT cycle.
          state_d = ST_WAIT;
`ifndef RMIO_SEQ_EU_DONE_EN
          wait_cnt_d = WAIT_W'(EU_LAT - 1);
`endif
        end else begin
          rd_idx_d = rd_idx_q + IN_CW'(1);
        end
      end

      ST_WAIT: begin
`ifdef RMIO_SEQ_EU_DONE_EN
        wait_over = eu_done;
`else
        // Counter was loaded with EU_LAT-1, so WAIT spans EU_LAT cycles.
        wait_over = (wait_cnt_q == '0);
        if (!wait_over) begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
`endif
        if (wait_over) begin
          if (out_cnt_q != '0) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        out_re    = OUTPUT_NUM'(1) << wr_idx_q;
        ram_we    = 1'b1;
        ram_waddr = dst_q[int'(wr_idx_q)*ADDR_W +: ADDR_W];
        ram_wdata = rmio.output_data;
        if (wr_idx_q + OUT_CW'(1) == out_cnt_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          wr_idx_d = wr_idx_q + OUT_CW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      ld_oh_q    <= '0;
      done_q     <= 1'b0;
`ifndef RMIO_SEQ_EU_DONE_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      ld_oh_q    <= ld_oh_d;
      done_q     <= done_d;
`ifndef RMIO_SEQ_EU_DONE_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign rmio.input_we   = ld_oh_q;
  assign rmio.input_data = (ld_oh_q != '0) ? ram_rdata : '0;
  assign rmio.output_re  = out_re;
  assign done            = done_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_rmio_seq.sv
// tb_rmio_seq - self-checking bench for rmio_seq.
// A timeline reference model predicts, for every cycle, the RF read/write
// traffic, EU slot strobes, cmd_ready and done directly from the command
// timing rules; the RF RAM is a read-only behavioural array and the EU output
// word is random bench-driven data.
module tb_rmio_seq;
  import rmio_pkg::*;

  localparam int INPUT_NUM  = 4;
  localparam int OUTPUT_NUM = 2;
  localparam int DATA_W     = 1408;
  localparam int ADDR_W     = 8;
  localparam int EU_LAT     = 4;
  localparam int IN_CW      = cnt_w(INPUT_NUM);
  localparam int OUT_CW     = cnt_w(OUTPUT_NUM);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [INPUT_NUM*ADDR_W-1:0]  cmd_src;
  logic [OUTPUT_NUM*ADDR_W-1:0] cmd_dst;
  logic [IN_CW-1:0]             cmd_in_cnt;
  logic [OUT_CW-1:0]            cmd_out_cnt;
  logic                         done;
  logic                         ram_re, ram_we;
  logic [ADDR_W-1:0]            ram_raddr, ram_waddr;
  logic [DATA_W-1:0]            ram_rdata, ram_wdata;
  logic [1:0]                   dbg_state;
`ifdef RMIO_SEQ_EU_DONE_EN
  logic                         eu_done;
`endif

  rmio_intf #(.INPUT_NUM(INPUT_NUM), .OUTPUT_NUM(OUTPUT_NUM), .DATA_W(DATA_W)) rmio_if ();

  rmio_seq #(
    .INPUT_NUM(INPUT_NUM), .OUTPUT_NUM(OUTPUT_NUM), .DATA_W(DATA_W),
    .ADDR_W(ADDR_W), .EU_LAT(EU_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_in_cnt(cmd_in_cnt), .cmd_out_cnt(cmd_out_cnt),
    .done(done),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .rmio(rmio_if),
`ifdef RMIO_SEQ_EU_DONE_EN
    .eu_done(eu_done),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- RF RAM model (read-only contents) ----------------
  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) if (ram_re) ram_rdata <= mem[ram_raddr];

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic                  re;
    logic [ADDR_W-1:0]     raddr;
    logic [INPUT_NUM-1:0]  iwe;
    logic [DATA_W-1:0]     idata;
    logic [OUTPUT_NUM-1:0] ore;
    logic                  we;
    logic [ADDR_W-1:0]     waddr;
  } cyc_exp_t;

  cyc_exp_t    tl [int];      // expected outputs keyed by absolute cycle
  logic [31:0] exp_q [$];     // expected done cycles, in order
  int  cyc;
  int  busy_until;
  bit  accepted_now;
  int  n_tests, n_fail;
`ifdef RMIO_SEQ_EU_DONE_EN
  bit                          wait_pending;
  int                          wait_from;
  int                          pend_m;
  logic [OUTPUT_NUM*ADDR_W-1:0] pend_dst;
`endif

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h (low 64 bits)", tag, cyc, got[63:0], exp[63:0]);
    end
  endtask

  function automatic cyc_exp_t tl_get(input int k);
    if (tl.exists(k)) return tl[k];
    return '0;
  endfunction

  function automatic bit model_busy();
`ifdef RMIO_SEQ_EU_DONE_EN
    if (wait_pending) return 1'b1;
`endif
    return cyc < busy_until;
  endfunction

  task automatic schedule_writes(input int ws, input int m,
                                 input logic [OUTPUT_NUM*ADDR_W-1:0] dst);
    cyc_exp_t e;
    for (int j = 0; j < m; j++) begin
      e        = tl_get(ws + j);
      e.ore    = '0;
      e.ore[j] = 1'b1;
      e.we     = 1'b1;
      e.waddr  = dst[j*ADDR_W +: ADDR_W];
      tl[ws + j] = e;
    end
    exp_q.push_back(32'(ws + m));
    busy_until = ws + m;
  endtask

  task automatic model_accept();
    cyc_exp_t e;
    int n, m;
    logic [ADDR_W-1:0] a;
    n = (int'(cmd_in_cnt) > INPUT_NUM) ? INPUT_NUM : int'(cmd_in_cnt);
    m = (int'(cmd_out_cnt) > OUTPUT_NUM) ? OUTPUT_NUM : int'(cmd_out_cnt);
    for (int k = 0; k < n; k++) begin
      a       = cmd_src[k*ADDR_W +: ADDR_W];
      e       = tl_get(cyc + 1 + k);
      e.re    = 1'b1;
      e.raddr = a;
      tl[cyc + 1 + k] = e;
      e        = tl_get(cyc + 2 + k);
      e.iwe    = '0;
      e.iwe[k] = 1'b1;
      e.idata  = mem[a];
      tl[cyc + 2 + k] = e;
    end
`ifdef RMIO_SEQ_EU_DONE_EN
    wait_pending = 1'b1;
    wait_from    = cyc + n + 1;
    pend_m       = m;
    pend_dst     = cmd_dst;
`else
    schedule_writes(cyc + n + EU_LAT + 1, m, cmd_dst);
`endif
    accepted_now = 1'b1;
  endtask

  task automatic model_step();
    accepted_now = 1'b0;
    if (rst) begin
      // Everything after this cycle is flushed by the reset.
      tl.delete();
      exp_q.delete();
      busy_until = cyc + 1;
`ifdef RMIO_SEQ_EU_DONE_EN
      wait_pending = 1'b0;
`endif
    end else begin
`ifdef RMIO_SEQ_EU_DONE_EN
      if (wait_pending && cyc >= wait_from && eu_done) begin
        wait_pending = 1'b0;
        schedule_writes(cyc + 1, pend_m, pend_dst);
      end
`endif
      if (cmd_valid && !model_busy()) model_accept();
    end
  endtask

  task automatic check_cycle();
    cyc_exp_t e;
    bit exp_ready, exp_done;
    e         = tl_get(cyc);
    exp_ready = !rst && !model_busy();
    exp_done  = 1'b0;
    if (exp_q.size() > 0 && exp_q[0] == 32'(cyc)) begin
      exp_done = 1'b1;
      void'(exp_q.pop_front());
    end
    check_eq("cmd_ready",  DATA_W'(cmd_ready),          DATA_W'(exp_ready));
    check_eq("done",       DATA_W'(done),               DATA_W'(exp_done));
    check_eq("ram_re",     DATA_W'(ram_re),             DATA_W'(e.re));
    check_eq("ram_raddr",  DATA_W'(ram_raddr),          DATA_W'(e.raddr));
    check_eq("input_we",   DATA_W'(rmio_if.input_we),   DATA_W'(e.iwe));
    check_eq("input_data", rmio_if.input_data,          e.idata);
    check_eq("output_re",  DATA_W'(rmio_if.output_re),  DATA_W'(e.ore));
    check_eq("ram_we",     DATA_W'(ram_we),             DATA_W'(e.we));
    check_eq("ram_waddr",  DATA_W'(ram_waddr),          DATA_W'(e.waddr));
    check_eq("ram_wdata",  ram_wdata, e.we ? rmio_if.output_data : '0);
    if (exp_ready) check_eq("dbg_idle", DATA_W'(dbg_state), DATA_W'(ST_IDLE));
    tl.delete(cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    check_cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    rmio_if.output_data = rand_word();
`ifdef RMIO_SEQ_EU_DONE_EN
    eu_done = ($urandom_range(0, 5) == 0);
`endif
  endtask

  task automatic scramble_cmd();
    cmd_src     = {$urandom(), $urandom()};
    cmd_dst     = 16'($urandom());
    cmd_in_cnt  = IN_CW'($urandom_range(0, 7));
    cmd_out_cnt = OUT_CW'($urandom_range(0, 3));
  endtask

  task automatic send_cmd(input logic [INPUT_NUM*ADDR_W-1:0] src,
                          input logic [OUTPUT_NUM*ADDR_W-1:0] dst,
                          input int n, input int m);
    int guard;
    cmd_valid   = 1'b1;
    cmd_src     = src;
    cmd_dst     = dst;
    cmd_in_cnt  = IN_CW'(n);
    cmd_out_cnt = OUT_CW'(m);
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!accepted_now && guard < 200);
    if (!accepted_now) check_eq("accept_timeout", DATA_W'(0), DATA_W'(1));
    cmd_valid = 1'b0;
    scramble_cmd();   // latched command must ignore later input changes
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (model_busy() && guard < 300) begin
      tick();
      guard++;
    end
    if (model_busy()) check_eq("drain_timeout", DATA_W'(0), DATA_W'(1));
    tick();
  endtask

  task automatic rand_cmd();
    send_cmd({$urandom(), $urandom()}, 16'($urandom()),
             $urandom_range(0, 7), $urandom_range(0, 3));
  endtask

  // ---------------- stimulus ----------------
  localparam logic [INPUT_NUM*ADDR_W-1:0]  SRC1 = {8'h20, 8'h01, 8'h07, 8'h03};
  localparam logic [OUTPUT_NUM*ADDR_W-1:0] DST1 = {8'h41, 8'h40};

  initial begin
    n_tests = 0;
    n_fail  = 0;
    busy_until = 0;
    accepted_now = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = rand_word();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    scramble_cmd();
    rmio_if.output_data = rand_word();
`ifdef RMIO_SEQ_EU_DONE_EN
    eu_done      = 1'b0;
    wait_pending = 1'b0;
`endif
    @(posedge clk);
    #1;
    cyc = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Full command, then in_cnt=0 only-write, then over-range counts.
    send_cmd(SRC1, DST1, 4, 2);
    drain();
    send_cmd(SRC1, {8'h00, 8'h05}, 0, 1);
    drain();
    send_cmd(SRC1, DST1, 7, 3);
    drain();
    // Zero-length command.
    send_cmd(SRC1, DST1, 0, 0);
    drain();

    // Second command held valid while the first runs.
    send_cmd(SRC1, DST1, 4, 2);
    send_cmd({8'h11, 8'h22, 8'h33, 8'h44}, {8'h55, 8'h66}, 2, 1);
    drain();

    // Reset mid-command (asserted in cycle 3 after the handshake).
    send_cmd(SRC1, DST1, 4, 2);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drain();

    // Randomized commands, back-to-back or spaced, with occasional resets.
    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(0, 2)) tick();
      rand_cmd();
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 10)) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
